// File: rtl/circular_right_shift_seq.sv
// circular_right_shift_seq
// Sequential right rotator: accepts a word and a shift amount, rotates the word
// right by one bit per clock, then presents the result until it is taken.
// Undoes left rotations performed elsewhere in the datapath.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for an input transfer; in_ready high
//   ST_SHIFT | rotating r_data right one bit per clock until r_count==0
//   ST_DONE  | result on o_out, out_valid high until downstream accepts
module circular_right_shift_seq #(
    parameter int WIDTH = 4,
    parameter int K_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in,
    input  logic [K_W-1:0]   i_k,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             o_busy
);

    // The shift counter must be able to express every rotation 0..WIDTH-1
    // and nothing more, otherwise the modulo-WIDTH wrap is lost.
    generate
        if ((2 ** K_W) != WIDTH) begin : g_bad_params
            $error("circular_right_shift_seq: 2**K_W must equal WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_out;
    logic [K_W-1:0]   r_count;
    logic             w_accept;
    logic             w_shift_end;

    assign w_accept    = i_in_valid && (r_state == ST_IDLE);
    assign w_shift_end = (r_state == ST_SHIFT) && (r_count == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; outputs come straight from the registered state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_in_valid)  w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_count == '0) w_next_state = ST_DONE;
            ST_DONE:  if (i_out_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Working word and remaining-rotation down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_data  <= i_in;
            r_count <= i_k;
        end else if ((r_state == ST_SHIFT) && (r_count != '0)) begin
            r_data  <= {r_data[0], r_data[WIDTH-1:1]};
            r_count <= r_count - K_W'(1);
        end
    end

    // Result register: loaded once on entry to DONE so o_out never shows
    // intermediate rotations and keeps its value through the following IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_shift_end) begin
            r_out <= r_data;
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign o_out       = r_out;

endmodule
